// File: rtl/stopwatch_ctrl_seq.sv
// stopwatch_ctrl_seq: control sequencer for the 4-digit BCD millisecond stopwatch.
//   - free-running 1 ms tick generator
//   - debouncer per button, each producing a one-cycle press pulse
//   - mode FSM issuing single-cycle cnt_en / cnt_clr strobes to the BCD counter
// Optional feature macro: INC_REPEAT_EN (auto-repeat while inc is held in IDLE/STOP).
module stopwatch_ctrl_seq #(
  parameter int TICK_DIV  = 100000,
  parameter int DEB_TICKS = 20
`ifdef INC_REPEAT_EN
  ,
  parameter int RPT_DELAY = 500,
  parameter int RPT_RATE  = 50
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic       tick_1ms,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  localparam int             TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]     DEB_LIMIT = 8'(DEB_TICKS);

  logic [TW-1:0] r_tick_cnt;
  logic          r_tick;

  // Tick divider: count 0..TICK_DIV-1, pulse registered one cycle after the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick     <= (r_tick_cnt == TICK_LAST);
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
    end
  end

  logic [2:0] w_btn_raw;
  logic [2:0] w_press;

  // Bit order: 0 = start/stop, 1 = inc, 2 = clear.
  assign w_btn_raw = {btn_clr, btn_inc, btn_ss};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic       r_sync1;
      logic       r_sync2;
      logic       r_stable;
      logic       r_stable_d;
      logic       r_armed;
      logic [7:0] r_cnt;

      // Two-flop synchroniser for the asynchronous button level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Tick-based debounce; r_armed blocks a press for a button held through reset
      // until it has been seen released at least once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_armed    <= 1'b0;
          r_cnt      <= 8'd0;
        end else begin
          r_stable_d <= r_stable;
          if (r_tick) begin
            if (!r_sync2) begin
              r_armed <= 1'b1;
            end
            if (r_sync2 != r_stable) begin
              if (r_cnt + 8'd1 == DEB_LIMIT) begin
                r_stable <= r_sync2;
                r_cnt    <= 8'd0;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_cnt <= 8'd0;
            end
          end
        end
      end

      assign w_press[gi] = r_stable & ~r_stable_d & r_armed;
    end
  endgenerate

  logic       w_p_ss;
  logic       w_p_inc;
  logic       w_p_clr;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_cnt_clr;
  logic       w_cnt_clr_next;
  logic       w_rpt_fire;

  assign w_p_ss  = w_press[0];
  assign w_p_inc = w_press[1];
  assign w_p_clr = w_press[2];

`ifdef INC_REPEAT_EN
  localparam logic [15:0] RPT_DELAY_L = 16'(RPT_DELAY);
  localparam logic [15:0] RPT_RATE_L  = 16'(RPT_RATE);

  logic [15:0] r_rpt_cnt;
  logic        r_rpt_phase;
  logic        w_rpt_idle;
  logic        w_rpt_hold;

  // Repeat only counts while sitting in IDLE/STOP; STEP is a one-cycle excursion
  // that belongs to the repeat, so it holds the count instead of clearing it.
  assign w_rpt_idle = (r_state == S_IDLE) || (r_state == S_STOP);
  assign w_rpt_hold = g_deb[1].r_stable && (r_state != S_RUN);
  assign w_rpt_fire = w_rpt_hold && w_rpt_idle && r_tick &&
                      (r_rpt_cnt + 16'd1 == (r_rpt_phase ? RPT_RATE_L : RPT_DELAY_L));

  // Auto-repeat timer: initial delay, then fixed rate until inc is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt_cnt   <= 16'd0;
      r_rpt_phase <= 1'b0;
    end else if (!w_rpt_hold) begin
      r_rpt_cnt   <= 16'd0;
      r_rpt_phase <= 1'b0;
    end else if (r_tick && w_rpt_idle) begin
      if (w_rpt_fire) begin
        r_rpt_cnt   <= 16'd0;
        r_rpt_phase <= 1'b1;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + 16'd1;
      end
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // Next-state logic; clear beats start/stop beats inc when pulses coincide.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_clr_next = 1'b0;
    case (r_state)
      S_IDLE, S_STOP: begin
        if (w_p_clr) begin
          w_state_next   = S_IDLE;
          w_cnt_clr_next = 1'b1;
        end else if (w_p_ss) begin
          w_state_next = S_RUN;
        end else if (w_p_inc || w_rpt_fire) begin
          w_state_next = S_STEP;
        end
      end
      S_RUN: begin
        if (w_p_ss) begin
          w_state_next = S_STOP;
        end
      end
      S_STEP:  w_state_next = S_STOP;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and registered clear strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt_clr <= w_cnt_clr_next;
    end
  end

  assign tick_1ms = r_tick;
  assign cnt_clr  = r_cnt_clr;
  assign cnt_en   = ((r_state == S_RUN) && r_tick) || (r_state == S_STEP);
  assign running  = (r_state == S_RUN);
  assign state    = r_state;

endmodule
